// File: rtl/booth_calc_sequencer.sv
// booth_calc_sequencer
//   Builds signed decimal operands A and B from debounced keypad strobes.
//   Issues a one-cycle start to the Booth multiplier, then waits for its
//   valid, with a timeout. Captures the product and chooses the value that
//   the 7-segment display path shows.
//
// Ports
//   clk, rst     system clock; synchronous active-high reset
//   key_strobe   one-cycle pulse per debounced key press
//   key_code     key codes:
//                  0-9 digit
//                  A   confirm A
//                  B   clear entry
//                  C   clear all
//                  D   equals
//                  E   toggle sign
//                  F   ignored
//   mul_valid    product valid from the multiplier (pulse or level)
//   mul_result   signed 2*W product from the multiplier
//   op_a, op_b   latched signed operands driven to the multiplier
//   mul_start    one-cycle start pulse, high while in START
//   result       captured signed product
//   disp_value   sign-extended value for the display formatter
//   state_o      encoded state:
//                  ENTER_A=0, ENTER_B=1, START=2, WAIT=3, DONE=4, ERR=5
//   entry_err    one-cycle pulse when a digit is rejected
//   err          high while in ERR
module booth_calc_sequencer #(
  parameter int W          = 8,
  parameter int MAX_DIGITS = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_strobe,
  input  logic [3:0]       key_code,
  input  logic             mul_valid,
  input  logic [2*W-1:0]   mul_result,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  output logic             mul_start,
  output logic [2*W-1:0]   result,
  output logic [2*W-1:0]   disp_value,
  output logic [2:0]       state_o,
  output logic             entry_err,
  output logic             err
);

  localparam int MAX_MAG = (2 ** (W - 1)) - 1;
  // The width margin keeps mag*10+9 from wrapping before it is compared.
  localparam int AW      = W + 4;
  localparam int CW      = $clog2(MAX_DIGITS + 1);
  localparam int TW      = $clog2(TIMEOUT);

  localparam logic [3:0] K_CONFIRM   = 4'hA;
  localparam logic [3:0] K_CLR_ENTRY = 4'hB;
  localparam logic [3:0] K_CLR_ALL   = 4'hC;
  localparam logic [3:0] K_EQUALS    = 4'hD;
  localparam logic [3:0] K_SIGN      = 4'hE;

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t          state_reg;
  logic [W-1:0]    mag_reg;
  logic [CW-1:0]   cnt_reg;
  logic            neg_reg;
  logic [TW-1:0]   tmo_reg;

  logic            key_digit;
  logic            clear_all;
  logic [AW-1:0]   acc;
  logic            digit_ok;
  logic [W-1:0]    acc_low;
  logic [W-1:0]    acc_entry;
  logic [W-1:0]    entry;

  function automatic logic [2*W-1:0] sext(input logic [W-1:0] v);
    return {{W{v[W-1]}}, v};
  endfunction

  assign key_digit = (key_code <= 4'd9);
  assign clear_all = key_strobe && (key_code == K_CLR_ALL);

  // Candidate magnitude if the pressed digit were appended.
  assign acc       = (AW'(mag_reg) * AW'(10)) + AW'(key_code);
  assign digit_ok  = (cnt_reg < CW'(MAX_DIGITS)) && (acc <= AW'(MAX_MAG));
  assign acc_low   = acc[W-1:0];
  assign acc_entry = neg_reg ? -acc_low : acc_low;
  assign entry     = neg_reg ? -mag_reg : mag_reg;

  assign state_o   = state_reg;

  // disp_value is loaded together with every state or entry change. This
  // keeps it in step with state_o, with no extra cycle of lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_ENTER_A;
      mag_reg    <= '0;
      cnt_reg    <= '0;
      neg_reg    <= 1'b0;
      tmo_reg    <= '0;
      op_a       <= '0;
      op_b       <= '0;
      result     <= '0;
      disp_value <= '0;
      mul_start  <= 1'b0;
      entry_err  <= 1'b0;
      err        <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      entry_err <= 1'b0;
      err       <= 1'b0;

      if (clear_all) begin
        // Clear-all beats everything, including a simultaneous mul_valid.
        state_reg  <= S_ENTER_A;
        mag_reg    <= '0;
        cnt_reg    <= '0;
        neg_reg    <= 1'b0;
        tmo_reg    <= '0;
        op_a       <= '0;
        op_b       <= '0;
        result     <= '0;
        disp_value <= '0;
      end else begin
        case (state_reg)
          S_ENTER_A, S_ENTER_B: begin
            if (key_strobe) begin
              if (key_digit) begin
                if (digit_ok) begin
                  mag_reg    <= acc_low;
                  cnt_reg    <= cnt_reg + CW'(1);
                  disp_value <= sext(acc_entry);
                end else begin
                  entry_err <= 1'b1;
                end
              end else begin
                case (key_code)
                  K_SIGN: begin
                    neg_reg    <= ~neg_reg;
                    disp_value <= sext(-entry);
                  end
                  K_CLR_ENTRY: begin
                    mag_reg    <= '0;
                    cnt_reg    <= '0;
                    neg_reg    <= 1'b0;
                    disp_value <= '0;
                  end
                  K_CONFIRM: begin
                    if (state_reg == S_ENTER_A) begin
                      op_a       <= entry;
                      mag_reg    <= '0;
                      cnt_reg    <= '0;
                      neg_reg    <= 1'b0;
                      disp_value <= '0;
                      state_reg  <= S_ENTER_B;
                    end
                  end
                  K_EQUALS: begin
                    if (state_reg == S_ENTER_B) begin
                      op_b       <= entry;
                      mag_reg    <= '0;
                      cnt_reg    <= '0;
                      neg_reg    <= 1'b0;
                      disp_value <= sext(entry);
                      // The start pulse is high for the whole START cycle.
                      mul_start  <= 1'b1;
                      state_reg  <= S_START;
                    end
                  end
                  default: ;
                endcase
              end
            end
          end

          S_START: begin
            tmo_reg   <= '0;
            state_reg <= S_WAIT;
          end

          S_WAIT: begin
            if (mul_valid) begin
              result     <= mul_result;
              disp_value <= mul_result;
              state_reg  <= S_DONE;
            end else if (tmo_reg == TW'(TIMEOUT - 1)) begin
              err        <= 1'b1;
              disp_value <= '0;
              state_reg  <= S_ERR;
            end else begin
              tmo_reg <= tmo_reg + TW'(1);
            end
          end

          S_DONE: begin
            // A digit key starts a new calculation with that digit as the
            // first digit. The previous result stays in place.
            if (key_strobe && key_digit) begin
              mag_reg    <= W'(key_code);
              cnt_reg    <= CW'(1);
              neg_reg    <= 1'b0;
              disp_value <= sext(W'(key_code));
              state_reg  <= S_ENTER_A;
            end
          end

          S_ERR: begin
            err <= 1'b1;
          end

          default: begin
            state_reg <= S_ENTER_A;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_booth_calc_sequencer.sv
// Directed testbench for booth_calc_sequencer (W=8, MAX_DIGITS=3, TIMEOUT=64).
module tb_booth_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_strobe;
  logic [3:0]  key_code;
  logic        mul_valid;
  logic [15:0] mul_result;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        mul_start;
  logic [15:0] result;
  logic [15:0] disp_value;
  logic [2:0]  state_o;
  logic        entry_err;
  logic        err;

  int total = 0;
  int bad   = 0;
  int starts_total = 0;
  int starts_base;

  booth_calc_sequencer #(.W(8), .MAX_DIGITS(3), .TIMEOUT(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_strobe (key_strobe),
    .key_code   (key_code),
    .mul_valid  (mul_valid),
    .mul_result (mul_result),
    .op_a       (op_a),
    .op_b       (op_b),
    .mul_start  (mul_start),
    .result     (result),
    .disp_value (disp_value),
    .state_o    (state_o),
    .entry_err  (entry_err),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Count start pulses away from the active edge.
  always @(negedge clk) if (mul_start) starts_total++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    key_strobe = 1'b1;
    key_code   = code;
    tick();
    key_strobe = 1'b0;
    key_code   = 4'hF;
  endtask

  initial begin
    rst = 1'b1; key_strobe = 1'b0; key_code = 4'hF;
    mul_valid = 1'b0; mul_result = 16'h0;
    tick(); tick();
    check_eq("rst state", 32'(state_o), 32'd0);
    check_eq("rst op_a", 32'(op_a), 32'h0);
    check_eq("rst disp", 32'(disp_value), 32'h0);
    check_eq("rst flags", 32'({mul_start, entry_err, err}), 32'h0);
    rst = 1'b0;

    // 12 x 3 with valid a few cycles after start
    starts_base = starts_total;
    press(4'd1); press(4'd2);
    check_eq("t1 disp 12", 32'(disp_value), 32'd12);
    press(4'hA);
    check_eq("t1 state B", 32'(state_o), 32'd1);
    check_eq("t1 op_a", 32'(op_a), 32'd12);
    check_eq("t1 disp clr", 32'(disp_value), 32'd0);
    press(4'hA);
    check_eq("t1 A ignored in B", 32'(state_o), 32'd1);
    press(4'd3); press(4'hD);
    check_eq("t1 state START", 32'(state_o), 32'd2);
    check_eq("t1 mul_start", 32'(mul_start), 32'd1);
    check_eq("t1 op_b", 32'(op_b), 32'd3);
    check_eq("t1 disp op_b", 32'(disp_value), 32'd3);
    tick();
    check_eq("t1 state WAIT", 32'(state_o), 32'd3);
    check_eq("t1 start low", 32'(mul_start), 32'd0);
    tick(); tick(); tick();
    mul_valid = 1'b1; mul_result = 16'd36;
    tick();
    mul_valid = 1'b0;
    check_eq("t1 state DONE", 32'(state_o), 32'd4);
    check_eq("t1 result", 32'(result), 32'd36);
    check_eq("t1 disp", 32'(disp_value), 32'd36);
    check_eq("t1 one start", 32'(starts_total - starts_base), 32'd1);

    // -15 x -9, valid on the first WAIT cycle
    press(4'hC);
    check_eq("t2 clr result", 32'(result), 32'd0);
    check_eq("t2 clr op_a", 32'(op_a), 32'd0);
    press(4'd1); press(4'd5); press(4'hE);
    check_eq("t2 disp -15", 32'(disp_value), 32'hFFF1);
    press(4'hA);
    check_eq("t2 op_a", 32'(op_a), 32'hF1);
    press(4'd9); press(4'hE);
    check_eq("t2 disp -9", 32'(disp_value), 32'hFFF7);
    press(4'hD);
    check_eq("t2 op_b", 32'(op_b), 32'hF7);
    tick();
    mul_valid = 1'b1; mul_result = 16'd135;
    tick();
    mul_valid = 1'b0;
    check_eq("t2 state DONE", 32'(state_o), 32'd4);
    check_eq("t2 result", 32'(result), 32'h0087);

    // digit rejection
    press(4'hC);
    press(4'd1); press(4'd2); press(4'd8);
    check_eq("t3 err 128", 32'(entry_err), 32'd1);
    check_eq("t3 disp 12", 32'(disp_value), 32'd12);
    tick();
    check_eq("t3 err pulse", 32'(entry_err), 32'd0);
    press(4'hB);
    check_eq("t3 clr entry", 32'(disp_value), 32'd0);
    press(4'd9); press(4'd9);
    check_eq("t3 no err 99", 32'(entry_err), 32'd0);
    press(4'd9);
    check_eq("t3 err 999", 32'(entry_err), 32'd1);
    check_eq("t3 disp 99", 32'(disp_value), 32'd99);
    press(4'hB);
    press(4'd0); press(4'd0); press(4'd0); press(4'd5);
    check_eq("t3 err cnt", 32'(entry_err), 32'd1);
    check_eq("t3 disp 0", 32'(disp_value), 32'd0);

    // timeout
    press(4'hB);
    press(4'd4);
    press(4'hD);
    check_eq("t4 D ignored in A", 32'(state_o), 32'd0);
    press(4'hA); press(4'd5); press(4'hD);
    tick();
    repeat (63) tick();
    check_eq("t4 still WAIT", 32'(state_o), 32'd3);
    tick();
    check_eq("t4 state ERR", 32'(state_o), 32'd5);
    check_eq("t4 err", 32'(err), 32'd1);
    check_eq("t4 disp 0", 32'(disp_value), 32'd0);
    press(4'd7); press(4'hD);
    check_eq("t4 keys ignored", 32'(state_o), 32'd5);
    check_eq("t4 err held", 32'(err), 32'd1);
    press(4'hC);
    check_eq("t4 exit state", 32'(state_o), 32'd0);
    check_eq("t4 exit err", 32'(err), 32'd0);
    check_eq("t4 exit ops", 32'({op_a, op_b}), 32'd0);

    // clear-all together with valid in WAIT; late valid ignored
    press(4'd2); press(4'hA); press(4'd3); press(4'hD);
    tick(); tick();
    key_strobe = 1'b1; key_code = 4'hC; mul_valid = 1'b1; mul_result = 16'd6;
    tick();
    key_strobe = 1'b0; key_code = 4'hF; mul_valid = 1'b0;
    check_eq("t5 state A", 32'(state_o), 32'd0);
    check_eq("t5 result 0", 32'(result), 32'd0);
    tick();
    mul_valid = 1'b1;
    tick();
    mul_valid = 1'b0;
    check_eq("t5 late state", 32'(state_o), 32'd0);
    check_eq("t5 late result", 32'(result), 32'd0);

    // other key with valid in WAIT, new digit from DONE, reset mid-WAIT
    press(4'd6); press(4'hA); press(4'd6); press(4'hD);
    tick();
    key_strobe = 1'b1; key_code = 4'd5; mul_valid = 1'b1; mul_result = 16'd36;
    tick();
    key_strobe = 1'b0; key_code = 4'hF; mul_valid = 1'b0;
    check_eq("t6 state DONE", 32'(state_o), 32'd4);
    check_eq("t6 result", 32'(result), 32'd36);
    press(4'd7);
    check_eq("t6 state A", 32'(state_o), 32'd0);
    check_eq("t6 disp 7", 32'(disp_value), 32'd7);
    check_eq("t6 result held", 32'(result), 32'd36);
    press(4'hA); press(4'd2); press(4'hD);
    tick();
    check_eq("t6 in WAIT", 32'(state_o), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6 rst state", 32'(state_o), 32'd0);
    check_eq("t6 rst ops", 32'({op_a, op_b}), 32'd0);
    check_eq("t6 rst result", 32'(result), 32'd0);
    check_eq("t6 rst disp", 32'(disp_value), 32'd0);
    check_eq("t6 rst flags", 32'({mul_start, entry_err, err}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_calc_sequencer.md
Name: booth_calc_sequencer

Overview:
Keypad-driven sequencer for the signed Booth multiplier path. Assembles decimal operands A and B from debounced key strobes and launches the multiplier with a single-cycle start. Waits for the multiplier's valid with a timeout, captures the product, and selects what the 7-segment display path shows. Sits between the keypad decoder and the BoothMul instance, replacing ad-hoc enable_A/enable_B sequencing.

Parameters:
W, 8, operand width (signed two's complement); product width is 2*W
MAX_DIGITS, 3, maximum decimal digits accepted per operand
TIMEOUT, 64, cycles to wait for mul_valid after mul_start before declaring error

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
key_strobe  in  1  one-cycle pulse per debounced key press
key_code  in  4  0-9 digit; 0xA confirm A; 0xB clear entry; 0xC clear all; 0xD equals; 0xE toggle sign; 0xF ignored
mul_valid  in  1  product valid from multiplier (may be a pulse or a level)
mul_result  in  2*W  signed product from multiplier
op_a  out  W  signed operand A to multiplier
op_b  out  W  signed operand B to multiplier
mul_start  out  1  one-cycle start pulse to multiplier
result  out  2*W  captured signed product
disp_value  out  2*W  signed value for display formatter
state_o  out  3  encoded FSM state (debug/LEDs)
entry_err  out  1  high for one cycle when a digit is rejected
err  out  1  high while in ERR state

Behaviour:
- Reset (clk edge with rst=1; rst wins over all inputs): state=ENTER_A; op_a, op_b, result, disp_value, entry magnitude, digit count, sign flag all 0; mul_start, entry_err, err all 0.
- State encoding on state_o: ENTER_A=0, ENTER_B=1, START=2, WAIT=3, DONE=4, ERR=5.
- Entry register: unsigned magnitude mag, digit count cnt, and neg flag. entry = neg ? -mag : mag. MAX_MAG = 2^(W-1)-1, which is 127 at W=8.
- Digit key in ENTER_A or ENTER_B:
  - Accept when cnt < MAX_DIGITS and mag*10+d <= MAX_MAG: mag <= mag*10+d, cnt++.
  - Otherwise leave mag unchanged and assert entry_err for exactly one cycle.
  - Compute intermediates at least W+4 bits wide so the overflow check itself cannot wrap.
- 0xE in ENTER states: toggle neg.
- 0xB in ENTER states: clear mag, cnt, neg. Latched operands are unaffected.
- 0xA:
  - In ENTER_A: op_a <= entry, clear entry, go to ENTER_B.
  - Ignored in all other states.
- 0xD:
  - In ENTER_B: op_b <= entry, clear entry, go to START.
  - Ignored in ENTER_A.
- START: mul_start=1 for exactly one cycle, zero the timeout counter, go to WAIT. Keys are ignored except 0xC.
- WAIT:
  - Timeout counter increments every cycle.
  - mul_valid=1: result <= mul_result, go to DONE.
  - Counter reaches TIMEOUT-1 without mul_valid: go to ERR.
  - Keys are ignored except 0xC.
- Latency: the result is registered on the first WAIT cycle that sees mul_valid. The first WAIT cycle is the cycle after mul_start, so an immediate valid is accepted.
- DONE:
  - Digit key: start a new calculation; go to ENTER_A with mag=d, cnt=1, neg=0, result held.
  - 0xA, 0xB, 0xD, 0xE: ignored.
- ERR: err=1. Only 0xC exits.
- 0xC in any state: go to ENTER_A and clear entry, op_a, op_b, result, and the timeout counter. mul_start is never issued from the cycle 0xC is seen.
- Simultaneous events in WAIT:
  - key_strobe with 0xC and mul_valid together: 0xC wins and the product is discarded.
  - Any other key with mul_valid: the product is captured and the key is dropped.
- mul_valid outside WAIT is ignored, including a late valid after an abort.
- disp_value (registered, sign-extended to 2*W bits):
  - ENTER_A, ENTER_B: live entry.
  - START, WAIT: op_b.
  - DONE: result.
  - ERR: 0.
- op_a and op_b are stable from latch until the next 0xC or the next A confirm. They never change while in START or WAIT.

Test Plan:
- Keys 1,2,A,3,D; multiplier returns valid 5 cycles after start with 36 -> op_a=12, op_b=3; one mul_start pulse; state START->WAIT->DONE; result=36; disp_value=36.
- Keys 1,5,E,A,9,E,D; model returns -15*-9 -> op_a=-15 (0xF1), op_b=-9 (0xF7); result=135 (0x0087).
- Keys 1,2,8 in ENTER_A -> third digit rejected; entry_err pulses one cycle; mag=12. Keys 9,9,9 -> only 99 kept, third 9 rejected.
- Complete entry, hold mul_valid low -> after TIMEOUT cycles state=ERR, err=1, disp_value=0. Digit and 0xD keys ignored; 0xC -> ENTER_A with all values cleared.
- 0xC and mul_valid together in WAIT -> state=ENTER_A, result=0. A late mul_valid two cycles later is ignored.
- In DONE with result=36, press 7 -> ENTER_A, disp_value=7, result still 36 internally. Assert rst mid-WAIT -> all outputs 0, state=ENTER_A next cycle.
